// File: rtl/chimp_game_if.sv
// rtl/chimp_game_if.sv - button, renderer-lookup and status bundle for the chimp game controller
// Ports: btn_up/down/left/right/sel move and select pulses; rd_row/rd_col lookup address;
//        rd_number looked-up cell value; state, p_row, p_col, level, expected game status.
interface chimp_game_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_sel;
  logic [1:0] rd_row;
  logic [1:0] rd_col;
  logic [3:0] rd_number;
  logic [2:0] state;
  logic [1:0] p_row;
  logic [1:0] p_col;
  logic [3:0] level;
  logic [3:0] expected;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, rd_row, rd_col,
    input  rd_number, state, p_row, p_col, level, expected
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, rd_row, rd_col,
    output rd_number, state, p_row, p_col, level, expected
  );
endinterface

// File: rtl/chimp_game_ctrl.sv
// rtl/chimp_game_ctrl.sv - chimp memory test game controller for a 3x3 grid
// Ports: clk system clock; reset async active-high; gif (slave) carries buttons,
//        renderer lookup address/data and the registered game status outputs.
module chimp_game_ctrl #(
  parameter int          START_LEVEL = 3,
  parameter int          MAX_LEVEL   = 9,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic         clk,
  input logic         reset,
  chimp_game_if.slave gif
);

  // PLACE is internal only; it reports as 0 on the state output.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHOW   = 3'd1;
  localparam logic [2:0] S_HIDDEN = 3'd2;
  localparam logic [2:0] S_WIN    = 3'd3;
  localparam logic [2:0] S_LOSE   = 3'd4;
  localparam logic [2:0] S_PLACE  = 3'd5;

  localparam logic [3:0] START_L = 4'(START_LEVEL);
  localparam logic [3:0] MAX_L   = 4'(MAX_LEVEL);

  logic [2:0]  fsm;
  logic [2:0]  fsm_nxt;
  logic [15:0] lfsr;
  logic [3:0]  board [9];
  logic [3:0]  cnt;
  logic [3:0]  cur_idx;
  logic [3:0]  rd_idx;
  logic [3:0]  plc_idx;
  logic [3:0]  cur_val;
  logic        plc_hit;
  logic        start_place;
  logic        playing;

  always_comb begin
    cur_idx     = {2'b00, gif.p_row} * 4'd3 + {2'b00, gif.p_col};
    rd_idx      = {2'b00, gif.rd_row} * 4'd3 + {2'b00, gif.rd_col};
    plc_idx     = lfsr[3:0];
    cur_val     = board[cur_idx];
    playing     = (fsm == S_SHOW) || (fsm == S_HIDDEN);
    start_place = gif.btn_sel && ((fsm == S_IDLE) || (fsm == S_WIN) || (fsm == S_LOSE));
    // A candidate cell is only taken while numbers remain to be placed.
    plc_hit = 1'b0;
    if ((fsm == S_PLACE) && (plc_idx < 4'd9) && (cnt <= gif.level))
      plc_hit = (board[plc_idx] == 4'd0);

    fsm_nxt = fsm;
    case (fsm)
      S_IDLE, S_WIN, S_LOSE: if (gif.btn_sel) fsm_nxt = S_PLACE;
      // cnt has moved past level once the last number was written.
      S_PLACE: if (cnt > gif.level) fsm_nxt = S_SHOW;
      S_SHOW, S_HIDDEN: begin
        if (gif.btn_sel && (cur_val != 4'd0)) begin
          if (cur_val == gif.expected)
            fsm_nxt = (gif.expected == gif.level) ? S_WIN : S_HIDDEN;
          else
            fsm_nxt = S_LOSE;
        end
      end
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm           <= S_IDLE;
      gif.state     <= S_IDLE;
      lfsr          <= LFSR_SEED;
      cnt           <= 4'd1;
      gif.p_row     <= 2'd0;
      gif.p_col     <= 2'd0;
      gif.level     <= START_L;
      gif.expected  <= 4'd1;
      gif.rd_number <= 4'd0;
      for (int i = 0; i < 9; i++) board[i] <= 4'd0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      fsm       <= fsm_nxt;
      gif.state <= (fsm_nxt == S_PLACE) ? S_IDLE : fsm_nxt;
      // Reads see the board before this edge's writes (old value on collision).
      gif.rd_number <= ((gif.rd_row == 2'd3) || (gif.rd_col == 2'd3)) ? 4'd0 : board[rd_idx];

      if (start_place) begin
        for (int i = 0; i < 9; i++) board[i] <= 4'd0;
        cnt <= 4'd1;
        if (fsm == S_WIN)
          gif.level <= (gif.level < MAX_L) ? gif.level + 4'd1 : MAX_L;
        else if (fsm == S_LOSE)
          gif.level <= START_L;
      end

      if (plc_hit) begin
        board[plc_idx] <= cnt;
        cnt            <= cnt + 4'd1;
      end

      if ((fsm == S_PLACE) && (cnt > gif.level))
        gif.expected <= 4'd1;

      if (playing) begin
        if (gif.btn_sel) begin
          // expected is never 0 here, so a match implies a non-empty cell.
          if (cur_val == gif.expected) begin
            board[cur_idx] <= 4'd0;
            gif.expected   <= gif.expected + 4'd1;
          end
        end else if (gif.btn_up) begin
          if (gif.p_row != 2'd0) gif.p_row <= gif.p_row - 2'd1;
        end else if (gif.btn_down) begin
          if (gif.p_row < 2'd2) gif.p_row <= gif.p_row + 2'd1;
        end else if (gif.btn_left) begin
          if (gif.p_col != 2'd0) gif.p_col <= gif.p_col - 2'd1;
        end else if (gif.btn_right) begin
          if (gif.p_col < 2'd2) gif.p_col <= gif.p_col + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chimp_game_ctrl.sv
// tb/tb_chimp_game_ctrl.sv - self-checking bench for chimp_game_ctrl
module tb_chimp_game_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  chimp_game_if gif();

  chimp_game_ctrl #(.START_LEVEL(3), .MAX_LEVEL(9), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk),
    .reset(reset),
    .gif(gif)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Free-running reference LFSR; snap holds its value just after a sel edge.
  logic [15:0] m_l;
  logic [15:0] snap;
  always @(posedge clk or posedge reset)
    if (reset) m_l <= 16'hACE1;
    else       m_l <= lfsr_step(m_l);

  int         mb [9];
  logic [3:0] got [9];
  int         pr = 0;
  int         pc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compute_place(input logic [15:0] s, input int lvl);
    logic [15:0] l;
    int n;
    int guard;
    l = s; n = 1; guard = 0;
    for (int i = 0; i < 9; i++) mb[i] = 0;
    while (n <= lvl && guard < 100000) begin
      if (l[3:0] < 4'd9 && mb[l[3:0]] == 0) begin
        mb[l[3:0]] = n;
        n++;
      end
      l = lfsr_step(l);
      guard++;
    end
  endtask

  task automatic pulse(input bit u, input bit d, input bit lf, input bit r, input bit s);
    @(negedge clk);
    gif.btn_up = u; gif.btn_down = d; gif.btn_left = lf; gif.btn_right = r; gif.btn_sel = s;
    @(negedge clk);
    gif.btn_up = 0; gif.btn_down = 0; gif.btn_left = 0; gif.btn_right = 0; gif.btn_sel = 0;
    snap = m_l;
    if (!s) begin
      if (u)       pr = (pr > 0) ? pr - 1 : 0;
      else if (d)  pr = (pr < 2) ? pr + 1 : 2;
      else if (lf) pc = (pc > 0) ? pc - 1 : 0;
      else if (r)  pc = (pc < 2) ? pc + 1 : 2;
    end
  endtask

  task automatic read_cell(input int r, input int c, output logic [3:0] v);
    @(negedge clk);
    gif.rd_row = 2'(r); gif.rd_col = 2'(c);
    @(negedge clk);
    v = gif.rd_number;
  endtask

  task automatic check_board(input string tag);
    for (int i = 0; i < 9; i++) read_cell(i / 3, i % 3, got[i]);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_cell%0d", tag, i), got[i], mb[i]);
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n;
    n = 0;
    while (gif.state !== 3'(s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, gif.state, s);
  endtask

  task automatic goto(input int r, input int c);
    while (pr < r) pulse(0, 1, 0, 0, 0);
    while (pr > r) pulse(1, 0, 0, 0, 0);
    while (pc < c) pulse(0, 0, 0, 1, 0);
    while (pc > c) pulse(0, 0, 1, 0, 0);
    chk("p_row", gif.p_row, pr);
    chk("p_col", gif.p_col, pc);
  endtask

  function automatic int find(input int v);
    for (int i = 0; i < 9; i++) if (mb[i] == v) return i;
    return 0;
  endfunction

  task automatic pick(input int v, input int lvl);
    int idx;
    idx = find(v);
    goto(idx / 3, idx % 3);
    pulse(0, 0, 0, 0, 1);
    mb[idx] = 0;
    chk($sformatf("state_after_%0d", v), gif.state, (v == lvl) ? 3 : 2);
    chk($sformatf("expected_after_%0d", v), gif.expected, v + 1);
  endtask

  task automatic play_round(input int lvl);
    int filled;
    compute_place(snap, lvl);
    wait_state(1, 3000, $sformatf("show_l%0d", lvl));
    chk("level", gif.level, lvl);
    check_board($sformatf("place_l%0d", lvl));
    filled = 0;
    for (int i = 0; i < 9; i++) if (got[i] != 0) filled++;
    chk("filled", filled, lvl);
    for (int v = 1; v <= lvl; v++) pick(v, lvl);
  endtask

  initial begin
    logic [3:0] v;
    int idx;
    int r0;
    int c0;
    gif.btn_up = 0; gif.btn_down = 0; gif.btn_left = 0; gif.btn_right = 0; gif.btn_sel = 0;
    gif.rd_row = 0; gif.rd_col = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    chk("rst_state", gif.state, 0);
    chk("rst_level", gif.level, 3);
    chk("rst_expected", gif.expected, 1);
    chk("rst_p_row", gif.p_row, 0);
    chk("rst_p_col", gif.p_col, 0);
    for (int i = 0; i < 9; i++) mb[i] = 0;
    check_board("idle");
    read_cell(3, 1, v); chk("rd_row3", v, 0);
    read_cell(1, 3, v); chk("rd_col3", v, 0);

    // First round.
    pulse(0, 0, 0, 0, 1);
    compute_place(snap, 3);
    wait_state(1, 3000, "show_r1");
    check_board("round1");

    // Edge saturation, then walk to the far corner.
    pulse(0, 0, 1, 0, 0);
    pulse(1, 0, 0, 0, 0);
    chk("edge_p_row", gif.p_row, 0);
    chk("edge_p_col", gif.p_col, 0);
    repeat (3) pulse(0, 0, 0, 1, 0);
    repeat (3) pulse(0, 1, 0, 0, 0);
    chk("corner_p_row", gif.p_row, 2);
    chk("corner_p_col", gif.p_col, 2);

    pick(1, 3);
    idx = find(0);
    idx = pr * 3 + pc;
    read_cell(pr, pc, v);
    chk("cleared_cell", v, 0);

    // sel + down on an empty cell: nothing changes.
    r0 = pr; c0 = pc;
    pulse(0, 1, 0, 0, 1);
    chk("seldown_p_row", gif.p_row, r0);
    chk("seldown_p_col", gif.p_col, c0);
    chk("seldown_state", gif.state, 2);
    chk("seldown_expected", gif.expected, 2);

    // Wrong order.
    idx = find(3);
    goto(idx / 3, idx % 3);
    pulse(0, 0, 0, 0, 1);
    chk("lose_state", gif.state, 4);
    check_board("lose");

    pulse(0, 0, 0, 0, 1);
    play_round(3);
    for (int lvl = 4; lvl <= 9; lvl++) begin
      pulse(0, 0, 0, 0, 1);
      play_round(lvl);
    end
    pulse(0, 0, 0, 0, 1);
    play_round(9);

    // Reset in the middle of a level-9 placement, away from any clock edge.
    pulse(0, 0, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", gif.state, 0);
    chk("arst_level", gif.level, 3);
    chk("arst_expected", gif.expected, 1);
    chk("arst_p_row", gif.p_row, 0);
    chk("arst_p_col", gif.p_col, 0);
    chk("arst_rd_number", gif.rd_number, 0);
    @(negedge clk);
    reset = 1'b0;
    pr = 0; pc = 0;
    for (int i = 0; i < 9; i++) mb[i] = 0;
    check_board("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chimp_game_ctrl.md
# chimp_game_ctrl

Game controller for the chimp memory test on the 3x3 VGA grid. It consumes debounced button pulses, places numbers 1..level at pseudo-random cells, tracks the player cursor and checks the selection order. It drives the `state`, `p_row`, `p_col` and per-cell `number` values consumed by the pixel renderer. A registered read port lets the renderer look up the number in any cell.

## Interface
- START_LEVEL, 3, count of numbers placed in the first round (1..MAX_LEVEL)
- MAX_LEVEL, 9, level ceiling (≤ 9, one number per cell)
- LFSR_SEED, 16'hACE1, nonzero reset value of the placement LFSR
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle debounced move pulses
- btn_sel  in  1  single-cycle debounced select/start pulse
- rd_row, rd_col  in  2 each  renderer cell lookup address
- rd_number  out  4  board value at (rd_row, rd_col), registered; 0 = empty
- state  out  3  0 IDLE/PLACE, 1 SHOW, 2 HIDDEN, 3 WIN, 4 LOSE
- p_row, p_col  out  2 each  cursor cell, range 0..2
- level  out  4  current round size
- expected  out  4  next number the player must select

## Operation
- Board: 9 cells × 4 bits. Cell index = row*3 + col.
- LFSR: 16-bit Fibonacci, free-running every cycle including IDLE. nb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], nb}.
- FSM states: IDLE, PLACE, SHOW, HIDDEN, WIN, LOSE. `state` output encoding is given above; PLACE reports 0.
- IDLE:
  - btn_sel → PLACE.
  - All other buttons are ignored.
- Entering PLACE, on the transition edge:
  - all cells are cleared;
  - place counter = 1.
- PLACE, each cycle:
  - c = l[3:0].
  - If c < 9 and cell c is empty: cell c = place counter, counter++.
  - When the counter has written `level`, the next edge goes → SHOW with expected = 1.
  - Buttons are ignored.
- SHOW / HIDDEN, per cycle, priority sel > up > down > left > right; only one action per cycle.
  - Moves saturate at the grid edges: no wrap. up decrements p_row, down increments p_row, left decrements p_col, right increments p_col.
  - sel on an empty cell: no effect.
  - sel on a cell holding `expected`:
    - the cell is cleared;
    - expected++;
    - SHOW → HIDDEN;
    - if expected was equal to level → WIN.
  - sel on a cell holding any other nonzero value → LOSE. The board is left intact.
- WIN: btn_sel → level = min(level+1, MAX_LEVEL), then → PLACE.
- LOSE: btn_sel → level = START_LEVEL, then → PLACE.
- rd_number: rd_row or rd_col equal to 3 returns 0.
- A write and a read of the same cell in the same cycle return the old value.

## Timing
- All outputs are registered.
- A button pulse sampled at edge N is reflected in the outputs after edge N.
- rd_number latency is 1 cycle after rd_row/rd_col.
- Reset values:
  - state 0 (IDLE);
  - p_row = p_col = 0;
  - level = START_LEVEL;
  - expected = 1;
  - board all 0;
  - rd_number = 0;
  - LFSR = LFSR_SEED.
- Reset asserted mid-round (any state): all registers return to their reset values immediately, without waiting for a clock edge.
- PLACE duration is data-dependent; at least `level` cycles.
- The cursor keeps its position across rounds; it is reset only by `reset`.
- Simultaneous sel and a move in the same cycle: only sel takes effect, and the cursor does not move.

## Test plan
- Reset then idle: after 10 cycles with no buttons, expect state=0, level=3, expected=1, p=(0,0), every cell reads 0 through the rd port.
- Start a round: pulse btn_sel in IDLE → state=1 within 3+N cycles. A rd-port scan then shows exactly one each of 1, 2 and 3, and six 0s, matching a bench LFSR model seeded 16'hACE1.
- Correct play: move the cursor to the cell holding 1 and sel → state=2, expected=2, that cell reads 0. Selecting 2 and then 3 → state=3.
- Wrong order: in HIDDEN with expected=2, sel on the cell holding 3 → state=4 and the board is unchanged. sel → level=3, and the next round starts.
- Edge and priority: at p=(0,0), pulse left and up → p stays (0,0). Pulse right and down 3 times each → p=(2,2). Same-cycle sel+down on an empty cell → no cursor change.
- Level ceiling and reset: win rounds repeatedly with MAX_LEVEL=9 → level holds at 9 and the placement fills all 9 cells. Asserting reset during PLACE → state=0, board clear, level=3 with no clock edge.
